// File: rtl/hwpq_stim_gen.sv
// hwpq_stim_gen: stimulus sequencer for the priority-queue test harness.
// Converts each LFSR word into one enqueue or dequeue request, holds it until
// the queue accepts it, advances the LFSR only on acceptance, and tracks queue
// occupancy so the queue is never overflowed or underflowed.
// Optional feature macro: HWPQ_STIM_DRAIN_EN (empty the queue at end of run).
module hwpq_stim_gen #(
    parameter int KEY_W   = 8,
    parameter int VAL_W   = 8,
    parameter int DEPTH   = 16,
    parameter int NUM_OPS = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [15:0]                  lfsr_q,
    output logic                         lfsr_enb,
    input  logic                         pq_rdy,
    output logic                         enq,
    output logic                         deq,
    output logic [KEY_W-1:0]             key,
    output logic [VAL_W-1:0]             val,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [$clog2(NUM_OPS+1)-1:0] ops_done,
    output logic                         busy,
    output logic                         done
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OPS_W = $clog2(NUM_OPS + 1);

`ifdef HWPQ_STIM_DRAIN_EN
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [OCC_W-1:0]   occ_next;
    logic [OPS_W-1:0]   ops_next;
    logic               sel_enq;

    // Only the low KEY_W bits and bit 15 of the LFSR word are meaningful here.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_q;

    // State, occupancy and run counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            occ      <= '0;
            ops_done <= '0;
        end else begin
            state    <= state_next;
            occ      <= occ_next;
            ops_done <= ops_next;
        end
    end

    // Operation select, handshake and next-state logic.
    always_comb begin
        state_next = state;
        occ_next   = occ;
        ops_next   = ops_done;
        sel_enq    = 1'b0;
        enq        = 1'b0;
        deq        = 1'b0;
        key        = '0;
        val        = '0;
        lfsr_enb   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    ops_next   = '0;
                end
            end

            ISSUE: begin
                // Empty queue forces an enqueue, full queue forces a dequeue.
                if (occ == '0) begin
                    sel_enq = 1'b1;
                end else if (occ == OCC_W'(DEPTH)) begin
                    sel_enq = 1'b0;
                end else begin
                    sel_enq = lfsr_q[15];
                end
                enq = sel_enq;
                deq = !sel_enq;
                key = lfsr_q[KEY_W-1:0];
                val = VAL_W'(ops_done);

                if (pq_rdy) begin
                    lfsr_enb = 1'b1;
                    ops_next = ops_done + OPS_W'(1);
                    if (sel_enq) begin
                        occ_next = occ + OCC_W'(1);
                    end else begin
                        occ_next = occ - OCC_W'(1);
                    end
                    if (ops_done == OPS_W'(NUM_OPS - 1)) begin
`ifdef HWPQ_STIM_DRAIN_EN
                        if (occ_next == '0) begin
                            state_next = DONE;
                        end else begin
                            state_next = DRAIN;
                        end
`else
                        state_next = DONE;
`endif
                    end
                end
            end

`ifdef HWPQ_STIM_DRAIN_EN
            DRAIN: begin
                // Drain dequeues do not consume LFSR words or count as run ops.
                deq = 1'b1;
                if (pq_rdy) begin
                    occ_next = occ - OCC_W'(1);
                    if (occ == OCC_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
`endif

            DONE: begin
                if (start) begin
                    state_next = ISSUE;
                    ops_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef HWPQ_STIM_DRAIN_EN
    assign busy = (state == ISSUE) || (state == DRAIN);
`else
    assign busy = (state == ISSUE);
`endif
    assign done = (state == DONE);

endmodule
